// File: rtl/multicycle_main_control.sv
// Multicycle CPU main control unit.
// Moore FSM that sequences fetch, decode, execute, memory and write-back
// for four instruction classes (R-type, load, store, branch-if-equal).
// Datapath strobes decode from the registered state. The only exceptions
// are the mem_ready-qualified IR/PC writes in FETCH, PCWrite=zero in
// BRANCH, and the instr_done pulse on a completing store.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   opcode        instruction class from the IR, sampled in DECODE
//   zero          ALU zero flag, used in BRANCH
//   mem_ready     memory access completes this cycle
//   PCWrite..PCSource, ALUsrcB, ALUop   datapath controls
//   state         current state code
//   illegal       unsupported opcode seen; sticks until reset
//   instr_done    one-cycle pulse when an instruction retires
//   retired       wrapping count of retired instructions
//
// state | meaning
// 0     | FETCH    read instruction, PC += 4
// 1     | DECODE   read registers, compute branch target, latch opcode
// 2     | EXEC_R   ALU operation on rs, rt
// 3     | WB_R     write ALU result to rd
// 4     | ADDR     compute effective address
// 5     | MEM_RD   load access, waits for mem_ready
// 6     | WB_MEM   write loaded data to rt
// 7     | MEM_WR   store access, waits for mem_ready
// 8     | BRANCH   compare, conditionally load branch target
// 9     | ILLEGAL  unsupported opcode, parked until reset
module multicycle_main_control #(
  parameter int OPW    = 2,
  parameter int OP_R   = 0,
  parameter int OP_LW  = 1,
  parameter int OP_SW  = 2,
  parameter int OP_BEQ = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUsrcA,
  output logic             ExtOp,
  output logic             PCSource,
  output logic [1:0]       ALUsrcB,
  output logic [1:0]       ALUop,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXEC_R  = 4'd2;
  localparam logic [3:0] S_WB_R    = 4'd3;
  localparam logic [3:0] S_ADDR    = 4'd4;
  localparam logic [3:0] S_MEM_RD  = 4'd5;
  localparam logic [3:0] S_WB_MEM  = 4'd6;
  localparam logic [3:0] S_MEM_WR  = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ILLEGAL = 4'd9;

  localparam logic [OPW-1:0] OPC_R   = OPW'(OP_R);
  localparam logic [OPW-1:0] OPC_LW  = OPW'(OP_LW);
  localparam logic [OPW-1:0] OPC_SW  = OPW'(OP_SW);
  localparam logic [OPW-1:0] OPC_BEQ = OPW'(OP_BEQ);

  logic [3:0]       state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        if (opcode == OPC_R)                           state_d = S_EXEC_R;
        else if (opcode == OPC_LW || opcode == OPC_SW) state_d = S_ADDR;
        else if (opcode == OPC_BEQ)                    state_d = S_BRANCH;
        else                                           state_d = S_ILLEGAL;
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      // the IR opcode may have moved on by now, so use the latched copy
      S_ADDR:   state_d = (op_q == OPC_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ILLEGAL: state_d = S_ILLEGAL;
      // codes 10-15 are unreachable; fall back to a clean fetch
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    ALUsrcA    = 1'b0;
    ExtOp      = 1'b0;
    PCSource   = 1'b0;
    ALUsrcB    = 2'b00;
    ALUop      = 2'b00;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUsrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUsrcB = 2'b11;
        ExtOp   = 1'b1;
      end
      S_EXEC_R: begin
        ALUsrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_WB_R: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
        ExtOp   = 1'b1;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        ALUsrcA    = 1'b1;
        ALUop      = 2'b01;
        PCSource   = 1'b1;
        PCWrite    = zero;
        instr_done = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  assign retired_d = instr_done ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
module tb_multicycle_main_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_ready = 1'b0;
  logic zero = 1'b0;
  logic [1:0] op_a = 2'd0;
  logic [2:0] op_b = 3'd0;

  // control vector bit order:
  // PCWrite IRWrite IorD MemRead MemWrite MemtoReg RegWrite RegDst ALUsrcA
  // ExtOp PCSource ALUsrcB[1:0] ALUop[1:0] illegal instr_done
  logic [16:0] a_ctrl, b_ctrl;
  logic [3:0]  a_state, b_state;
  logic [15:0] a_ret;
  logic [1:0]  b_ret;

  localparam int B_PCW  = 16;
  localparam int B_MWR  = 12;
  localparam int B_M2R  = 11;
  localparam int B_RW   = 10;
  localparam int B_RD   = 9;
  localparam int B_PCS  = 6;
  localparam int B_ILL  = 1;
  localparam int B_DONE = 0;

  int checks = 0;
  int failures = 0;

  // per-instance model: remaining state path of the current instruction
  int m_seq [2][8];
  int m_len [2];
  int m_pos [2];
  int m_ret [2];

  always #5 clk = ~clk;

  multicycle_main_control dut_a (
    .clk(clk), .rst(rst), .opcode(op_a), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(a_ctrl[16]), .IRWrite(a_ctrl[15]), .IorD(a_ctrl[14]),
    .MemRead(a_ctrl[13]), .MemWrite(a_ctrl[12]), .MemtoReg(a_ctrl[11]),
    .RegWrite(a_ctrl[10]), .RegDst(a_ctrl[9]), .ALUsrcA(a_ctrl[8]),
    .ExtOp(a_ctrl[7]), .PCSource(a_ctrl[6]), .ALUsrcB(a_ctrl[5:4]),
    .ALUop(a_ctrl[3:2]), .state(a_state), .illegal(a_ctrl[1]),
    .instr_done(a_ctrl[0]), .retired(a_ret)
  );

  multicycle_main_control #(.OPW(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .opcode(op_b), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(b_ctrl[16]), .IRWrite(b_ctrl[15]), .IorD(b_ctrl[14]),
    .MemRead(b_ctrl[13]), .MemWrite(b_ctrl[12]), .MemtoReg(b_ctrl[11]),
    .RegWrite(b_ctrl[10]), .RegDst(b_ctrl[9]), .ALUsrcA(b_ctrl[8]),
    .ExtOp(b_ctrl[7]), .PCSource(b_ctrl[6]), .ALUsrcB(b_ctrl[5:4]),
    .ALUop(b_ctrl[3:2]), .state(b_state), .illegal(b_ctrl[1]),
    .instr_done(b_ctrl[0]), .retired(b_ret)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] exp_ctrl(input int st, input bit mr, input bit z);
    logic pcw, irw, iord, mrd, mwr, m2r, rw, rd, asa, ext, pcs, ill, done;
    logic [1:0] asb, aop;
    {pcw, irw, iord, mrd, mwr, m2r, rw, rd, asa, ext, pcs, ill, done} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      0: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1: begin asb = 2'b11; ext = 1; end
      2: begin asa = 1; aop = 2'b10; end
      3: begin rw = 1; rd = 1; done = 1; end
      4: begin asa = 1; asb = 2'b10; ext = 1; end
      5: begin mrd = 1; iord = 1; end
      6: begin rw = 1; m2r = 1; done = 1; end
      7: begin mwr = 1; iord = 1; done = mr; end
      8: begin asa = 1; aop = 2'b01; pcs = 1; pcw = z; done = 1; end
      9: ill = 1;
      default: ;
    endcase
    return {pcw, irw, iord, mrd, mwr, m2r, rw, rd, asa, ext, pcs, asb, aop, ill, done};
  endfunction

  task automatic model_reset(input int i);
    m_seq[i][0] = 0;
    m_len[i] = 1;
    m_pos[i] = 0;
    m_ret[i] = 0;
  endtask

  // Advance one clock: an instruction is FETCH, DECODE, then a
  // class-specific path; FETCH and memory states wait on mem_ready.
  task automatic model_step(input int i, input int opc, input bit mr, input int cnt_w);
    int cur;
    cur = m_seq[i][m_pos[i]];
    if (cur == 3 || cur == 6 || cur == 8 || (cur == 7 && mr))
      m_ret[i] = (m_ret[i] + 1) % (1 << cnt_w);
    if (cur == 9) return;
    if ((cur == 0 || cur == 5 || cur == 7) && !mr) return;
    m_pos[i] = 0;
    if (cur == 0) begin
      m_seq[i][0] = 1; m_len[i] = 1;
    end else if (cur == 1) begin
      case (opc)
        0: begin m_seq[i][0] = 2; m_seq[i][1] = 3; m_len[i] = 2; end
        1: begin m_seq[i][0] = 4; m_seq[i][1] = 5; m_seq[i][2] = 6; m_len[i] = 3; end
        2: begin m_seq[i][0] = 4; m_seq[i][1] = 7; m_len[i] = 2; end
        3: begin m_seq[i][0] = 8; m_len[i] = 1; end
        default: begin m_seq[i][0] = 9; m_len[i] = 1; end
      endcase
    end else begin
      // locate cur in the path and move past it
      int k;
      k = 0;
      while (k < m_len[i] - 1 && m_seq[i][k] != cur) k++;
      if (k + 1 < m_len[i]) m_pos[i] = k + 1;
      else begin m_seq[i][0] = 0; m_len[i] = 1; end
    end
  endtask

  task automatic check_all();
    chk("a_state", 32'(a_state), 32'(m_seq[0][m_pos[0]]));
    chk("a_ctrl", 32'(a_ctrl), 32'(exp_ctrl(m_seq[0][m_pos[0]], mem_ready, zero)));
    chk("a_retired", 32'(a_ret), 32'(m_ret[0]));
    chk("b_state", 32'(b_state), 32'(m_seq[1][m_pos[1]]));
    chk("b_ctrl", 32'(b_ctrl), 32'(exp_ctrl(m_seq[1][m_pos[1]], mem_ready, zero)));
    chk("b_retired", 32'(b_ret), 32'(m_ret[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      model_step(0, int'(op_a), mem_ready, 16);
      model_step(1, int'(op_b), mem_ready, 2);
    end
    @(negedge clk);
    check_all();
  endtask

  // called just after a falling edge; asserts reset between clock edges
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    int n, s5, waits;
    int wrap_exp [5];
    wrap_exp = '{1, 2, 3, 0, 1};
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_ret", 32'(a_ret), 32'd0);
    mem_ready = 1'b1;
    rst = 1'b0;

    // R-type, no waits: 0,1,2,3,0
    op_a = 2'd0; op_b = 3'd0;
    cycle(); chk("r_s1", 32'(a_state), 32'd1);
    cycle(); chk("r_s2", 32'(a_state), 32'd2);
    cycle(); chk("r_s3", 32'(a_state), 32'd3);
    chk("r_wb", 32'({a_ctrl[B_RW], a_ctrl[B_RD], a_ctrl[B_DONE]}), 32'b111);
    cycle(); chk("r_s0", 32'(a_state), 32'd0);
    chk("r_ret", 32'(a_ret), 32'd1);
    chk("r_done_low", 32'(a_ctrl[B_DONE]), 32'd0);

    // load with two wait cycles in MEM_RD
    op_a = 2'd1; op_b = 3'd1; n = 0; s5 = 0; waits = 0;
    do begin
      cycle(); n++;
      if (a_state == 4'd6) chk("lw_wb", 32'({a_ctrl[B_M2R], a_ctrl[B_RW]}), 32'b11);
      if (a_state == 4'd5) begin
        s5++;
        if (waits < 2) begin mem_ready = 1'b0; waits++; end
        else mem_ready = 1'b1;
      end else mem_ready = 1'b1;
    end while (a_state != 4'd0 && n < 40);
    chk("lw_cycles", 32'(n), 32'd7);
    chk("lw_s5_cycles", 32'(s5), 32'd3);

    // branch taken then not taken
    for (int r = 0; r < 2; r++) begin
      op_a = 2'd3; op_b = 3'd3; zero = (r == 0); n = 0;
      do begin
        cycle(); n++;
        if (a_state == 4'd8) begin
          chk("beq_pcw", 32'(a_ctrl[B_PCW]), (r == 0) ? 32'd1 : 32'd0);
          chk("beq_pcs", 32'(a_ctrl[B_PCS]), 32'd1);
        end
      end while (a_state != 4'd0 && n < 40);
      chk("beq_cycles", 32'(n), 32'd3);
    end

    // illegal opcode on the 3-bit instance sticks until reset
    op_a = 2'd0; op_b = 3'd7;
    cycle(); cycle();
    for (int k = 0; k < 20; k++) begin
      cycle();
      chk("ill_hold", 32'({b_state, b_ctrl[B_ILL]}), 32'({4'd9, 1'b1}));
    end
    do_reset();
    chk("ill_clr", 32'({b_state, b_ctrl[B_ILL]}), 32'd0);

    // reset in the middle of a stalled store
    op_a = 2'd2; op_b = 3'd2; mem_ready = 1'b1;
    cycle(); cycle(); cycle();
    chk("sw_s7", 32'(a_state), 32'd7);
    mem_ready = 1'b0;
    cycle();
    chk("sw_mwr", 32'(a_ctrl[B_MWR]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("sw_rst_mwr", 32'(a_ctrl[B_MWR]), 32'd0);
    chk("sw_rst_state", 32'(a_state), 32'd0);
    chk("sw_rst_ret", 32'(a_ret), 32'd0);
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    check_all();
    rst = 1'b0;
    mem_ready = 1'b1;

    // 2-bit retired counter wraps
    op_a = 2'd0; op_b = 3'd0;
    for (int k = 0; k < 5; k++) begin
      repeat (4) cycle();
      chk("wrap_ret", 32'(b_ret), 32'(wrap_exp[k]));
    end

    // randomized traffic
    for (int it = 0; it < 3000; it++) begin
      mem_ready = ($urandom_range(3) != 0);
      zero = 1'($urandom_range(1));
      op_a = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) op_b = 3'(4 + $urandom_range(3));
      else op_b = 3'($urandom_range(3));
      if ($urandom_range(79) == 0) do_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
MULTICYCLE_MAIN_CONTROL -- requirements
Module: multicycle_main_control

Interface
REQ-001 SHALL have parameter OPW, default 2, meaning opcode width (>=2).
REQ-002 SHALL have parameters OP_R/OP_LW/OP_SW/OP_BEQ, defaults 0/1/2/3, meaning class encodings.
REQ-003 SHALL have parameter CNT_W, default 16, meaning retired-instruction counter width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  system clock, all state changes on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 opcode  in  OPW  instruction opcode from IR, valid from DECODE onward.
REQ-008 zero  in  1  ALU zero flag, sampled in BRANCH.
REQ-009 mem_ready  in  1  memory access completes this cycle.
REQ-010 PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, RegDst, ALUsrcA, ExtOp, PCSource  out  1 each  datapath strobes/selects.
REQ-011 ALUsrcB  out  2  00 reg B, 01 const 4, 10 sign/zero-ext imm, 11 imm<<2.
REQ-012 ALUop  out  2  00 add, 01 sub, 10 funct-decoded.
REQ-013 state  out  4  current state code; illegal out 1; instr_done out 1; retired out CNT_W.

Function
REQ-014 SHALL be a Moore FSM. All outputs SHALL decode from the registered state, except where noted. Every output not listed for a state SHALL be 0.
REQ-015 FETCH(0): MemRead=1, ALUsrcB=01, IRWrite=PCWrite=mem_ready. SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-016 DECODE(1): ALUsrcB=11, ExtOp=1. SHALL latch opcode into op_q. Next state: R->EXEC_R, LW/SW->ADDR, BEQ->BRANCH, any other encoding->ILLEGAL.
REQ-017 EXEC_R(2): ALUsrcA=1, ALUop=10. Next state: WB_R.
REQ-018 WB_R(3): RegWrite=1, RegDst=1. Next state: FETCH.
REQ-019 ADDR(4): ALUsrcA=1, ALUsrcB=10, ExtOp=1. Next state: MEM_RD if op_q==OP_LW, else MEM_WR.
REQ-020 MEM_RD(5): MemRead=1, IorD=1. SHALL hold until mem_ready=1, then go to WB_MEM.
REQ-021 WB_MEM(6): RegWrite=1, MemtoReg=1, RegDst=0. Next state: FETCH.
REQ-022 MEM_WR(7): MemWrite=1, IorD=1. SHALL hold until mem_ready=1, then go to FETCH.
REQ-023 BRANCH(8): ALUsrcA=1, ALUop=01, PCSource=1, PCWrite=zero (combinational on zero). Next state: FETCH.
REQ-024 ILLEGAL(9): illegal=1, all strobes 0. SHALL stay in ILLEGAL until rst.
REQ-025 Codes 10-15 are unreachable and SHALL recover to FETCH on the next clock.
REQ-026 instr_done SHALL be a 1-cycle pulse, asserted in WB_R, WB_MEM, BRANCH, and MEM_WR when mem_ready=1.
REQ-027 retired SHALL increment by 1 on each cycle where instr_done=1, wrapping modulo 2^CNT_W without saturation.
REQ-028 Latency with mem_ready held at 1: R=4, LW=5, SW=4, BEQ=3 cycles, FETCH to FETCH.
REQ-029 mem_ready held low SHALL extend FETCH, MEM_RD and MEM_WR indefinitely, with no timeout and no strobe change.

Reset
REQ-030 rst=1 SHALL force state=FETCH, op_q=0, retired=0, illegal=0 immediately, independent of clk.
REQ-031 Reset SHALL abort any instruction in progress. A write strobe in progress (MemWrite, RegWrite) SHALL drop on rst assertion.
REQ-032 After rst deasserts, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-033 OPW=2, opcode=00, mem_ready=1 -> states 0,1,2,3,0. RegWrite=RegDst=1 in cycle 4. instr_done pulses once. retired=1.
REQ-034 opcode=01, mem_ready low for 2 cycles in MEM_RD -> state 5 held 3 cycles, then 6 with MemtoReg=RegWrite=1. Total 7 cycles.
REQ-035 opcode=11, zero=1, then repeat with zero=0 -> PCWrite=PCSource=1 in state 8 in the first run. PCWrite=0 in the second run. Both take 3 cycles.
REQ-036 OPW=3, opcode=3'b111 -> state 9, illegal=1, held 20 cycles. rst -> state 0, illegal=0.
REQ-037 opcode=10, rst asserted mid-MEM_WR -> MemWrite drops with no clock edge. retired unchanged (0).
REQ-038 CNT_W=2, run 5 R-type instructions -> retired sequence 1,2,3,0,1.
